// File: rtl/hazard_flush_ctrl_pkg.sv
// Shared CPU definitions used by the hazard/flush controller, its hazard
// detector and the forwarding unit.
//   REG_W    : default register specifier width
//   REG_ZERO : the hard-wired zero register, which never creates a hazard
//   hz_state_t : stall sequencer states
package cpu_pkg;
   localparam int REG_W = 5;
   localparam logic [REG_W-1:0] REG_ZERO = '0;

   typedef enum logic [0:0] {
      RUN     = 1'b0,
      MC_WAIT = 1'b1
   } hz_state_t;
endpackage

// File: rtl/hazard_flush_ctrl_if.sv
// Bundle between the ID stage and the hazard/flush controller.
//   master : pipeline side, drives ID/EX event inputs, receives stall/flush controls
//   slave  : controller side
// Optional macro HAZ_PERF_CNT_EN adds the stall_cycles / flush_events counters.
interface hazard_flush_ctrl_if #(
   parameter int REG_W = cpu_pkg::REG_W
);
   logic [REG_W-1:0] id_rs;
   logic [REG_W-1:0] id_rt;
   logic             idex_memread;
   logic [REG_W-1:0] idex_rt;
   logic             id_branch_taken;
   logic             id_jump;
   logic             mc_start;
   logic             pc_write;
   logic             ifid_write;
   logic             if_flush;
   logic             idex_bubble;
   logic             mc_busy;
`ifdef HAZ_PERF_CNT_EN
   logic [31:0]      stall_cycles;
   logic [31:0]      flush_events;
`endif

   modport master (
      output id_rs, id_rt, idex_memread, idex_rt, id_branch_taken, id_jump, mc_start,
`ifdef HAZ_PERF_CNT_EN
      input  stall_cycles, flush_events,
`endif
      input  pc_write, ifid_write, if_flush, idex_bubble, mc_busy
   );

   modport slave (
      input  id_rs, id_rt, idex_memread, idex_rt, id_branch_taken, id_jump, mc_start,
`ifdef HAZ_PERF_CNT_EN
      output stall_cycles, flush_events,
`endif
      output pc_write, ifid_write, if_flush, idex_bubble, mc_busy
   );
endinterface

// File: rtl/hazard_flush_ctrl_hazard_detect.sv
// Purely combinational load-use detector. Shared with the forwarding unit.
//   id_rs, id_rt  : source specifiers of the instruction in ID
//   idex_memread  : instruction in EX is a load
//   idex_rt       : load destination in EX
//   load_use      : ID consumes the register the EX load is still fetching
module hazard_detect
   import cpu_pkg::*;
#(
   parameter int REG_W = cpu_pkg::REG_W
) (
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             idex_memread,
   input  logic [REG_W-1:0] idex_rt,
   output logic             load_use
);
   // The zero register is constant, so a load "targeting" it never stalls.
   assign load_use = idex_memread
                   & (idex_rt != REG_W'(REG_ZERO))
                   & ((idex_rt == id_rs) | (idex_rt == id_rt));
endmodule

// File: rtl/hazard_flush_ctrl.sv
// Pipeline hazard and flush controller sitting in ID. Drives PC write-enable,
// IF/ID write-enable and flush, and the ID/EX bubble insert. Handles load-use
// stalls, taken branch/jump flushes and fixed-latency multi-cycle EX ops.
//   clk, reset : clock, synchronous active-high reset
//   hz (slave) : ID event inputs and stall/flush outputs (see hazard_flush_ctrl_if)
// Outputs are combinational from state and inputs (no added latency).
// Optional macro HAZ_PERF_CNT_EN adds stall_cycles / flush_events counters.
module hazard_flush_ctrl
   import cpu_pkg::*;
#(
   parameter int REG_W  = cpu_pkg::REG_W,
   parameter int MC_LAT = 4,
   parameter int CNT_W  = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   hazard_flush_ctrl_if.slave   hz
);
   // Counter holds "remaining stall cycles minus one", so MC_LAT fits in CNT_W bits.
   localparam logic [CNT_W-1:0] MC_LOAD = CNT_W'(MC_LAT - 1);

   hz_state_t        state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             load_use;
   logic             redirect;

   hazard_detect #(.REG_W(REG_W)) u_detect (
      .id_rs        (hz.id_rs),
      .id_rt        (hz.id_rt),
      .idex_memread (hz.idex_memread),
      .idex_rt      (hz.idex_rt),
      .load_use     (load_use)
   );

   assign redirect = hz.id_branch_taken | hz.id_jump;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= RUN;
         cnt_reg   <= '0;
      end else begin
         case (state_reg)
            RUN: begin
               // A load-use stall holds the mc op in ID; it restarts next cycle.
               if (!load_use && hz.mc_start) begin
                  state_reg <= MC_WAIT;
                  cnt_reg   <= MC_LOAD;
               end
            end
            MC_WAIT: begin
               if (cnt_reg == '0) state_reg <= RUN;
               else               cnt_reg   <= cnt_reg - 1'b1;
            end
            default: state_reg <= RUN;
         endcase
      end
   end

   always_comb begin
      hz.pc_write    = 1'b1;
      hz.ifid_write  = 1'b1;
      hz.if_flush    = 1'b0;
      hz.idex_bubble = 1'b0;
      hz.mc_busy     = 1'b0;
      // Reset drops any stall in the same cycle.
      if (!reset) begin
         if (state_reg == MC_WAIT) begin
            hz.pc_write    = 1'b0;
            hz.ifid_write  = 1'b0;
            hz.idex_bubble = 1'b1;
            hz.mc_busy     = 1'b1;
         end else if (load_use) begin
            hz.pc_write    = 1'b0;
            hz.ifid_write  = 1'b0;
            hz.idex_bubble = 1'b1;
         end else if (redirect) begin
            // Flush dominates write in IF/ID; PC loads the target.
            hz.if_flush    = 1'b1;
         end
      end
   end

`ifdef HAZ_PERF_CNT_EN
   logic [31:0] stall_cycles_reg;
   logic [31:0] flush_events_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cycles_reg <= '0;
         flush_events_reg <= '0;
      end else begin
         if (!hz.pc_write) stall_cycles_reg <= stall_cycles_reg + 32'd1;
         if (hz.if_flush)  flush_events_reg <= flush_events_reg + 32'd1;
      end
   end

   assign hz.stall_cycles = stall_cycles_reg;
   assign hz.flush_events = flush_events_reg;
`endif
endmodule

// File: tb/tb_hazard_flush_ctrl.sv
module tb_hazard_flush_ctrl;
   localparam int REG_W  = 5;
   localparam int MC_LAT = 4;
   localparam int CNT_W  = 3;

   typedef struct {
      string       tag;
      logic [4:0]  outs;   // {pc_write, ifid_write, if_flush, idex_bubble, mc_busy}
      logic [4:0]  mask;
      logic [31:0] stalls;
      logic [31:0] flushes;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb_q[$];

   // Reference model state
   int          m_wait = 0;
   logic [31:0] m_stalls = 0;
   logic [31:0] m_flushes = 0;

   always #5 clk = ~clk;

   hazard_flush_ctrl_if #(.REG_W(REG_W)) hz_if ();

   hazard_flush_ctrl #(.REG_W(REG_W), .MC_LAT(MC_LAT), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .hz    (hz_if)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // One cycle: drive, predict, compare at negedge, advance model to next edge.
   task automatic step(input string tag, input logic rst,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic mr, input logic [4:0] xrt,
                       input logic br, input logic jp, input logic mc);
      exp_t e;
      exp_t got;
      logic lu;
      logic [4:0] obs;
      reset                 = rst;
      hz_if.id_rs           = rs;
      hz_if.id_rt           = rt;
      hz_if.idex_memread    = mr;
      hz_if.idex_rt         = xrt;
      hz_if.id_branch_taken = br;
      hz_if.id_jump         = jp;
      hz_if.mc_start        = mc;

      lu = mr && (xrt != 5'd0) && ((xrt == rs) || (xrt == rt));
      e.tag = tag;
      e.mask = 5'b11111;
      e.stalls = m_stalls;
      e.flushes = m_flushes;
      if (rst)             e.outs = 5'b11000;
      else if (m_wait > 0) e.outs = 5'b00011;
      else if (lu)         e.outs = 5'b00010;
      else if (br || jp) begin
         e.outs = 5'b11100;
         e.mask = 5'b10111;   // ifid_write is don't-care under flush
      end else             e.outs = 5'b11000;
      sb_q.push_back(e);

      @(negedge clk);
      obs = {hz_if.pc_write, hz_if.ifid_write, hz_if.if_flush, hz_if.idex_bubble, hz_if.mc_busy};
      if (sb_q.size() == 0) begin
         check_eq("scoreboard_empty", 32'd1, 32'd0);
      end else begin
         got = sb_q.pop_front();
         check_eq(got.tag, 32'(obs & got.mask), 32'(got.outs & got.mask));
`ifdef HAZ_PERF_CNT_EN
         check_eq({got.tag, "_stalls"},  hz_if.stall_cycles, got.stalls);
         check_eq({got.tag, "_flushes"}, hz_if.flush_events, got.flushes);
`endif
      end
      $display("cycle %-14s rst=%b rs=%0d rt=%0d mr=%b xrt=%0d br=%b j=%b mc=%b -> outs=%b exp=%b",
               tag, rst, rs, rt, mr, xrt, br, jp, mc, obs, e.outs);

      // Model update at the coming rising edge
      if (rst) begin
         m_wait = 0;
         m_stalls = 0;
         m_flushes = 0;
      end else begin
         if (e.outs[4] == 1'b0) m_stalls++;
         if (e.outs[2] == 1'b1) m_flushes++;
         if (m_wait > 0)            m_wait--;
         else if (!lu && mc)        m_wait = MC_LAT;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      @(posedge clk);
      #1;
      step("reset0",     1, 0, 0, 0, 0, 0, 0, 0);
      step("reset1",     1, 0, 0, 0, 0, 0, 0, 0);
      step("idle",       0, 1, 2, 0, 0, 0, 0, 0);
      step("lu_rs",      0, 5, 2, 1, 5, 0, 0, 0);
      step("after_lu",   0, 5, 2, 0, 5, 0, 0, 0);
      step("lu_rt",      0, 3, 7, 1, 7, 0, 0, 0);
      step("zero_reg",   0, 0, 0, 1, 0, 0, 0, 0);
      step("no_match",   0, 1, 2, 1, 6, 0, 0, 0);
      step("branch",     0, 1, 2, 0, 0, 1, 0, 0);
      step("after_br",   0, 1, 2, 0, 0, 0, 0, 0);
      step("jump",       0, 1, 2, 0, 0, 0, 1, 0);
      step("lu_plus_br", 0, 5, 2, 1, 5, 1, 0, 0);
      step("br_retry",   0, 5, 2, 0, 5, 1, 0, 0);
      step("mc_start",   0, 1, 2, 0, 0, 0, 0, 1);
      step("mc_w1",      0, 1, 2, 0, 0, 0, 0, 0);
      step("mc_w2_br",   0, 1, 2, 0, 0, 1, 0, 1);
      step("mc_w3",      0, 1, 2, 1, 1, 0, 1, 0);
      step("mc_w4",      0, 1, 2, 0, 0, 0, 0, 0);
      step("mc_done",    0, 1, 2, 0, 0, 0, 0, 0);
      step("mc_lu",      0, 4, 2, 1, 4, 0, 0, 1);
      step("mc_retry",   0, 4, 2, 0, 4, 0, 0, 1);
      step("mcr_w1",     0, 1, 2, 0, 0, 0, 0, 0);
      step("mcr_w2",     0, 1, 2, 0, 0, 0, 0, 0);
      step("mcr_w3",     0, 1, 2, 0, 0, 0, 0, 0);
      step("mcr_w4",     0, 1, 2, 0, 0, 0, 0, 0);
      step("mc_br",      0, 1, 2, 0, 0, 1, 0, 1);
      step("mcb_w1",     0, 1, 2, 0, 0, 0, 0, 0);
      step("mcb_w2",     0, 1, 2, 0, 0, 0, 0, 0);
      step("mc_rst_in",  1, 1, 2, 0, 0, 0, 0, 0);
      step("post_rst",   0, 1, 2, 0, 0, 0, 0, 0);
      step("post_rst2",  0, 1, 2, 0, 0, 1, 0, 0);
      for (int i = 0; i < 200; i++) begin
         step("rand",
              ($urandom_range(39) == 0),
              5'($urandom_range(3)), 5'($urandom_range(3)),
              ($urandom_range(2) == 0), 5'($urandom_range(3)),
              ($urandom_range(7) == 0), ($urandom_range(11) == 0),
              ($urandom_range(9) == 0));
      end
      check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/hazard_flush_ctrl.md
Name: hazard_flush_ctrl

Overview:
- Pipeline hazard and flush controller that drives the IF/ID pipeline register's write-enable and flush inputs, the PC write-enable, and the ID/EX bubble insert.
- Detects load-use hazards, taken branches and jumps, and multi-cycle EX operations.
- Sequences stalls with a small FSM and a down-counter.
- Sits in ID, beside the register-file read, and feeds the IF stage, IF/ID and ID/EX.

Parameters:
REG_W, 5, register specifier width
MC_LAT, 4, stall cycles inserted for a multi-cycle EX op (legal range 1..2**CNT_W)
CNT_W, 3, width of the multi-cycle stall counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
id_rs  input  REG_W  rs field of the instruction in ID
id_rt  input  REG_W  rt field of the instruction in ID
idex_memread  input  1  instruction in EX is a load
idex_rt  input  REG_W  destination rt of the instruction in EX
id_branch_taken  input  1  branch in ID resolved taken
id_jump  input  1  jump in ID
mc_start  input  1  instruction in ID is a multi-cycle EX op (mult/div)
pc_write  output  1  PC update enable
ifid_write  output  1  IF/ID write enable
if_flush  output  1  IF/ID flush (zeroes instruction and PC)
idex_bubble  output  1  force ID/EX control fields to zero
mc_busy  output  1  high while in MC_WAIT

Behaviour:
- One clock domain. Synchronous, active-high reset: when reset=1 at a rising edge, state<=RUN and cnt<=0.
- Outputs are combinational from state and inputs; zero added latency.
- Neutral outputs (RUN, no event): pc_write=1, ifid_write=1, if_flush=0, idex_bubble=0, mc_busy=0. These also apply while reset is asserted.
- load_use = idex_memread & (idex_rt!=0) & ((idex_rt==id_rs)|(idex_rt==id_rt)). Register 0 never hazards.
- FSM states: RUN, MC_WAIT.
- RUN, priority 1, load_use=1:
  - pc_write=0, ifid_write=0, idex_bubble=1, if_flush=0.
  - Branch, jump and mc_start are ignored this cycle; they are re-evaluated next cycle when the load has left EX.
  - Stay in RUN.
- RUN, priority 2, id_branch_taken|id_jump:
  - if_flush=1; pc_write=1 so the target is loaded.
  - ifid_write value is don't-care, because flush dominates write in IF/ID.
- RUN, priority 3, mc_start:
  - The op advances into EX normally this cycle.
  - Next state MC_WAIT, cnt<=MC_LAT-1.
  - If mc_start coincides with a taken branch or jump: flush is applied AND MC_WAIT is entered.
- MC_WAIT:
  - pc_write=0, ifid_write=0, idex_bubble=1, if_flush=0, mc_busy=1.
  - All ID event inputs are ignored.
  - If cnt==0, next state RUN; else cnt<=cnt-1.
  - Exactly MC_LAT stall cycles; MC_LAT=1 gives a single stall cycle.
- Reset asserted mid MC_WAIT: return to RUN on that edge and drop the stall immediately.
- Counter never wraps: decrement is only performed when cnt!=0.

Optional Feature:
HAZ_PERF_CNT_EN
- Defined:
  - Adds outputs stall_cycles[31:0] and flush_events[31:0].
  - stall_cycles increments every cycle with pc_write=0.
  - flush_events increments every cycle with if_flush=1.
  - Both counters clear on reset and wrap at 2**32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package cpu_pkg: REG_W constant, state enum hz_state_t {RUN, MC_WAIT}, REG_ZERO constant.
- Natural sub-module: hazard_detect, a purely combinational load_use compare, reused by the forwarding unit.
- FSM and counter stay in hazard_flush_ctrl.

Test Plan:
- Load-use: idex_memread=1, idex_rt=5, id_rs=5 for one cycle -> pc_write=0, ifid_write=0, idex_bubble=1 that cycle; neutral outputs the next cycle once idex_memread=0.
- Zero register: idex_memread=1, idex_rt=0, id_rt=0 -> no stall; neutral outputs.
- Branch: id_branch_taken=1 with no hazard -> if_flush=1, pc_write=1 for exactly that cycle.
- Load-use plus branch in the same cycle -> stall only, if_flush=0; next cycle with branch still asserted -> if_flush=1.
- Multi-cycle op: mc_start=1 pulse with MC_LAT=4 -> mc_busy=1 and pc_write=0 for exactly 4 cycles, then neutral; a branch asserted during MC_WAIT is ignored.
- Reset during MC_WAIT (cycle 2 of 4) -> next cycle RUN, pc_write=1, mc_busy=0; with HAZ_PERF_CNT_EN defined, both counters read 0.
